// File: rtl/cic_buffer_pkg.sv
// Shared helpers for the CIC sample buffer: midscale offset, output shift,
// and the offset/shift/saturate conversion from unsigned CIC code to signed word.
package cic_buffer_pkg;

  // Offset that maps the unsigned CIC midscale code to zero.
  function automatic logic [63:0] midscale(input int clock_width);
    return 64'd1 << (3 * clock_width - 1);
  endfunction

  // Number of LSBs dropped when narrowing the CIC word to the output width.
  function automatic int fmt_shift(input int clock_width, input int out_width);
    return 3 * clock_width - out_width;
  endfunction

  // Offset to signed (wrapping at 3*clock_width+1 bits), floor-shift, saturate.
  function automatic logic signed [63:0] sat_format(input logic [63:0] cap,
                                                   input int clock_width,
                                                   input int out_width);
    int nb;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    nb = 3 * clock_width + 1;
    s  = $signed(cap - midscale(clock_width));
    s  = (s <<< (64 - nb)) >>> (64 - nb);
    s  = s >>> fmt_shift(clock_width, out_width);
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/echip65_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered level.
// A push while full is accepted only when a pop happens in the same cycle.
module echip65_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/cic_sample_buffer.sv
// Samples the CIC output once per decimation period, drops the settling
// captures, converts to a saturated signed word and queues it in a FIFO.
module cic_sample_buffer
  import cic_buffer_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3 * CLOCK_WIDTH + 1,
  parameter int OUT_WIDTH         = 16,
  parameter int CAPTURE_PHASE     = DECIMATION_FACTOR / 2,
  parameter int SETTLE_SAMPLES    = 4,
  parameter int DEPTH             = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUMBITS-1:0]         cic_out,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int SW = ($clog2(SETTLE_SAMPLES + 1) > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  logic                   en_q;
  logic [CLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [NUMBITS-1:0]     cap_q, cap_d;
  logic                   cap_vld_q, cap_vld_d;
  logic                   ovf_q, ovf_d;

  logic                   rise, capture, settled, pop, drop;
  logic                   fifo_full, fifo_empty;
  logic [OUT_WIDTH-1:0]   fmt_word;

  assign rise     = enable && !en_q;
  assign capture  = enable && (cnt_q == CLOCK_WIDTH'(CAPTURE_PHASE));
  assign settled  = (settle_q == SW'(SETTLE_SAMPLES));
  assign out_valid = !fifo_empty;
  assign pop      = out_valid && out_ready;
  // A push while full is only lost when no pop frees a slot in the same cycle.
  assign drop     = cap_vld_q && fifo_full && !pop;
  assign overflow = ovf_q;
  assign fmt_word = OUT_WIDTH'(sat_format(64'(cap_q), CLOCK_WIDTH, OUT_WIDTH));

  // Phase counter, settle counter, capture register and overflow next-state.
  always_comb begin
    cnt_d     = (!enable || rise) ? '0 : cnt_q + CLOCK_WIDTH'(1);
    settle_d  = settle_q;
    if (rise) begin
      settle_d = '0;
    end else if (capture && !settled) begin
      settle_d = settle_q + SW'(1);
    end
    cap_d     = capture ? cic_out : cap_q;
    cap_vld_d = capture && settled && !rise;
    ovf_d     = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset also discards any sample waiting to be written.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      en_q      <= enable;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  echip65_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cap_vld_q),
    .wdata_i (fmt_word),
    .pop_i   (pop),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Directed bench for cic_sample_buffer at D=256, OUT_WIDTH=16, DEPTH=8.
// Cycle numbers are counted from the cycle in which enable is raised:
// capture k happens in cycle 129+256k, its word is pushed at the end of
// cycle 130+256k and is visible from cycle 131+256k.
module tb_cic_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [24:0] cic_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        clear_ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cic_sample_buffer #(
    .DECIMATION_FACTOR (256),
    .OUT_WIDTH         (16),
    .SETTLE_SAMPLES    (4),
    .DEPTH             (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cic_out    (cic_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  function automatic int cap_cyc(input int k);
    return 129 + 256 * k;
  endfunction

  function automatic logic [24:0] word_code(input int j);
    return 25'h800000 + 25'(256 * j);
  endfunction

  // Reset, then raise enable; the current cycle becomes cycle 0.
  task automatic start_stream();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    cic_out = 25'h800000;
    step(); step();
    reset = 1'b0;
    step();
    enable = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    cic_out = 25'h1234567;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d want=0", out_valid); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d want=0", fill_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0d want=0", overflow); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h want=0000", out_data); end
  endtask

  task automatic test_settle();
    start_stream();
    run_to(1154);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL settle_valid_early got=%0d want=0", out_valid); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL settle_fill_early got=%0d want=0", fill_level); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL settle_valid_first got=%0d want=1", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL settle_data_mid got=%h want=0000", out_data); end
    run_to(1154 + 256);
    checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL settle_fill_gap got=%0d want=1", fill_level); end
    step();
    checks++; if (fill_level !== 4'd2) begin failures++; $display("FAIL settle_fill_second got=%0d want=2", fill_level); end
  endtask

  task automatic test_format();
    logic [24:0] codes [4];
    logic [15:0] want  [4];
    codes[0] = 25'h1000000; want[0] = 16'h7fff;
    codes[1] = 25'h0000000; want[1] = 16'h8000;
    codes[2] = 25'h0800100; want[2] = 16'h0001;
    codes[3] = 25'h07fffff; want[3] = 16'hffff;
    start_stream();
    for (int i = 0; i < 4; i++) begin
      run_to(cap_cyc(4 + i));
      cic_out = codes[i];
    end
    run_to(131 + 256 * 7);
    checks++; if (fill_level !== 4'd4) begin failures++; $display("FAIL fmt_fill got=%0d want=4", fill_level); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== want[i]) begin
        failures++; $display("FAIL fmt_word%0d got=%h want=%h", i, out_data, want[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fmt_drained got=%0d want=0", out_valid); end
  endtask

  task automatic test_overflow();
    start_stream();
    for (int k = 4; k <= 11; k++) begin
      run_to(cap_cyc(k));
      cic_out = word_code(k - 3);
    end
    run_to(131 + 256 * 11);
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL ovf_fill8 got=%0d want=8", fill_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop got=%0d want=0", overflow); end
    run_to(cap_cyc(12));
    cic_out = word_code(9);
    run_to(131 + 256 * 12);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d want=1", overflow); end
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL ovf_fill_after_drop got=%0d want=8", fill_level); end
    run_to(131 + 256 * 12 + 5);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0d want=0", overflow); end
    run_to(cap_cyc(13));
    cic_out = word_code(10);
    run_to(130 + 256 * 13);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clear got=%0d want=1", overflow); end
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (out_data !== 16'(j)) begin
        failures++; $display("FAIL ovf_kept_word%0d got=%h want=%h", j, out_data, 16'(j));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL ovf_drain_fill got=%0d want=0", fill_level); end
  endtask

  task automatic test_full_pop();
    start_stream();
    for (int k = 4; k <= 11; k++) begin
      run_to(cap_cyc(k));
      cic_out = word_code(k - 3);
    end
    run_to(cap_cyc(12));
    cic_out = word_code(9);
    run_to(130 + 256 * 12);
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL fullpop_pre_fill got=%0d want=8", fill_level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL fullpop_fill got=%0d want=8", fill_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%0d want=0", overflow); end
    out_ready = 1'b1;
    for (int j = 2; j <= 9; j++) begin
      checks++;
      if (out_data !== 16'(j)) begin
        failures++; $display("FAIL fullpop_word%0d got=%h want=%h", j, out_data, 16'(j));
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reenable();
    start_stream();
    run_to(1155);
    checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL reen_first_fill got=%0d want=1", fill_level); end
    run_to(1300);
    enable = 1'b0;
    run_to(1500);
    checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL reen_idle_fill got=%0d want=1", fill_level); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reen_idle_valid got=%0d want=1", out_valid); end
    enable = 1'b1;
    cic_out = word_code(1);
    cyc = 0;
    run_to(1154);
    checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL reen_settle_fill got=%0d want=1", fill_level); end
    step();
    checks++; if (fill_level !== 4'd2) begin failures++; $display("FAIL reen_new_fill got=%0d want=2", fill_level); end
    out_ready = 1'b1;
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reen_old_word got=%h want=0000", out_data); end
    step();
    out_ready = 1'b0;
    checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL reen_new_word got=%h want=0001", out_data); end
  endtask

  task automatic test_reset_mid();
    start_stream();
    run_to(cap_cyc(4) + 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0d want=0", out_valid); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL rstmid_fill got=%0d want=0", fill_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%0d want=0", overflow); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rstmid_data got=%h want=0000", out_data); end
    step(); step(); step();
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL rstmid_no_write got=%0d want=0", fill_level); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_format();
    test_overflow();
    test_full_pop();
    test_reenable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
